// File: rtl/traffic_demand_counter.sv
// traffic_demand_counter
// Front-end for smart_traffic_light: synchronizes and debounces the raw lane
// detectors and pedestrian button into saturating 3-bit demand counts. It
// discharges vehicle counts while the fed-back light for that lane is green
// and conditions the raw emergency request into a held s_emergency level.
// Optional build macro: QUEUE_OVF_EN adds the sticky 4-bit ovf output
// (bit3 main, bit2 left, bit1 sec, bit0 ped).
// The emergency FSM state is kept in emg_state so checkers can bind to it.

module traffic_demand_counter #(
    parameter int DEBOUNCE      = 3,
    parameter int DISCHARGE_DIV = 4,
    parameter int EMG_HOLD      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       main_det,
    input  logic       left_det,
    input  logic       sec_det,
    input  logic       p_btn,
    input  logic       emg_req,
    input  logic [3:0] m_LRYG,
    input  logic [2:0] s_RYG,
    input  logic       p,
    output logic [2:0] main_num,
    output logic [2:0] left_num,
    output logic [2:0] sec_num,
    output logic [2:0] p_num,
    output logic       s_emergency
`ifdef QUEUE_OVF_EN
    ,
    output logic [3:0] ovf
`endif
);

    localparam logic [3:0] DB_M1  = 4'(DEBOUNCE - 1);
    localparam logic [3:0] DIV_M1 = 4'(DISCHARGE_DIV - 1);
    localparam logic [7:0] HOLD_M1 = 8'(EMG_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_HOLD   = 2'd2
    } emg_state_t;

    // Bit layout for detector vectors: 3 main, 2 left, 1 sec, 0 ped.
    // sync*[4] carries the emergency request.
    logic [4:0]      sync1;
    logic [4:0]      sync2;
    logic [3:0][3:0] run;
    logic [3:0]      db;
    logic [3:0]      db_d;
    logic [3:0]      arrival;

    // Vehicle lanes: 2 main, 1 left, 0 sec.
    logic [2:0]      green;
    logic [2:0][3:0] div;
    logic [2:0]      depart;
    logic [2:0][2:0] vcnt;
    logic [2:0][2:0] vcnt_nxt;

    logic [2:0]      p_cnt;
    logic [2:0]      p_cnt_nxt;
    logic            p_q;
    logic            p_rise;

    emg_state_t      emg_state;
    emg_state_t      emg_state_nxt;
    logic [7:0]      hold_cnt;
    logic [7:0]      hold_cnt_nxt;

    // Only the green bits of the fed-back lights matter here.
    logic            unused_light_bits;
    assign unused_light_bits = ^{m_LRYG[2:1], s_RYG[2:1]};

    assign green   = {m_LRYG[0], m_LRYG[3], s_RYG[0]};
    assign arrival = db & ~db_d;
    assign p_rise  = p & ~p_q;

    // Two-flop synchronizers for every raw asynchronous input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {emg_req, main_det, left_det, sec_det, p_btn};
            sync2 <= sync1;
        end
    end

    // Debounce: run length of consecutive highs; accept once it reaches DEBOUNCE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run  <= '0;
            db   <= '0;
            db_d <= '0;
        end else begin
            db_d <= db;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i]) begin
                    if (run[i] != 4'd15) begin
                        run[i] <= run[i] + 4'd1;
                    end
                    if (run[i] >= DB_M1) begin
                        db[i] <= 1'b1;
                    end
                end else begin
                    run[i] <= '0;
                    db[i]  <= 1'b0;
                end
            end
        end
    end

    // Departure pulse on the last cycle of each full green period.
    always_comb begin
        depart = '0;
        for (int i = 0; i < 3; i++) begin
            depart[i] = green[i] && (div[i] == DIV_M1);
        end
    end

    // Discharge dividers run only while green; any non-green cycle drops the partial period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!green[i] || depart[i]) begin
                    div[i] <= '0;
                end else begin
                    div[i] <= div[i] + 4'd1;
                end
            end
        end
    end

    // Next counts: arrival/departure saturate at 7/0, and cancel when simultaneous.
    always_comb begin
        vcnt_nxt = vcnt;
        for (int i = 0; i < 3; i++) begin
            case ({arrival[i + 1], depart[i]})
                2'b10: if (vcnt[i] != 3'd7) vcnt_nxt[i] = vcnt[i] + 3'd1;
                2'b01: if (vcnt[i] != 3'd0) vcnt_nxt[i] = vcnt[i] - 3'd1;
                default: vcnt_nxt[i] = vcnt[i];
            endcase
        end
        p_cnt_nxt = p_cnt;
        if (p_rise) begin
            p_cnt_nxt = 3'd0;
        end else if (!p && arrival[0] && (p_cnt != 3'd7)) begin
            p_cnt_nxt = p_cnt + 3'd1;
        end
    end

    // Count registers and walk-signal edge detector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vcnt  <= '0;
            p_cnt <= '0;
            p_q   <= 1'b0;
        end else begin
            vcnt  <= vcnt_nxt;
            p_cnt <= p_cnt_nxt;
            p_q   <= p;
        end
    end

    assign main_num = vcnt[2];
    assign left_num = vcnt[1];
    assign sec_num  = vcnt[0];
    assign p_num    = p_cnt;

`ifdef QUEUE_OVF_EN
    logic [3:0] ovf_hit;

    // An arrival is lost when the count is already full and nothing departs.
    always_comb begin
        ovf_hit = '0;
        for (int i = 0; i < 3; i++) begin
            ovf_hit[i + 1] = arrival[i + 1] && !depart[i] && (vcnt[i] == 3'd7);
        end
        ovf_hit[0] = arrival[0] && !p && (p_cnt == 3'd7);
    end

    // Sticky overflow flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= '0;
        end else begin
            ovf <= ovf | ovf_hit;
        end
    end
`endif

    // Emergency FSM state register; s_emergency follows the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            emg_state   <= S_IDLE;
            hold_cnt    <= '0;
            s_emergency <= 1'b0;
        end else begin
            emg_state   <= emg_state_nxt;
            hold_cnt    <= hold_cnt_nxt;
            s_emergency <= (emg_state_nxt != S_IDLE);
        end
    end

    // Emergency next-state: any synchronized high activates, a drop starts the hold.
    always_comb begin
        emg_state_nxt = emg_state;
        hold_cnt_nxt  = hold_cnt;
        case (emg_state)
            S_IDLE: begin
                if (sync2[4]) emg_state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (!sync2[4]) begin
                    emg_state_nxt = S_HOLD;
                    hold_cnt_nxt  = HOLD_M1;
                end
            end
            S_HOLD: begin
                if (sync2[4]) begin
                    emg_state_nxt = S_ACTIVE;
                end else if (hold_cnt == 8'd0) begin
                    emg_state_nxt = S_IDLE;
                end else begin
                    hold_cnt_nxt = hold_cnt - 8'd1;
                end
            end
            default: emg_state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_traffic_demand_counter.sv
// tb_traffic_demand_counter
// Directed bench for traffic_demand_counter with default parameters.
// Build with +define+QUEUE_OVF_EN to also exercise the ovf port.

module tb_traffic_demand_counter;

    logic       clk;
    logic       rst;
    logic       main_det, left_det, sec_det, p_btn, emg_req;
    logic [3:0] m_LRYG;
    logic [2:0] s_RYG;
    logic       p;
    logic [2:0] main_num, left_num, sec_num, p_num;
    logic       s_emergency;
`ifdef QUEUE_OVF_EN
    logic [3:0] ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [2:0] exp_q[$];

    traffic_demand_counter dut (
        .clk         (clk),
        .rst         (rst),
        .main_det    (main_det),
        .left_det    (left_det),
        .sec_det     (sec_det),
        .p_btn       (p_btn),
        .emg_req     (emg_req),
        .m_LRYG      (m_LRYG),
        .s_RYG       (s_RYG),
        .p           (p),
        .main_num    (main_num),
        .left_num    (left_num),
        .sec_num     (sec_num),
        .p_num       (p_num),
        .s_emergency (s_emergency)
`ifdef QUEUE_OVF_EN
        ,
        .ovf         (ovf)
`endif
    );

    // Clock and reset defaults
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One active edge, then settle 1ns so outputs are sampled away from the edge.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Clean detector pulse: high for hi samples, then low long enough to re-arm.
    task automatic pulse(input int lane, input int hi);
        case (lane)
            3: main_det = 1'b1;
            2: left_det = 1'b1;
            1: sec_det  = 1'b1;
            default: p_btn = 1'b1;
        endcase
        tick(hi);
        main_det = 1'b0;
        left_det = 1'b0;
        sec_det  = 1'b0;
        p_btn    = 1'b0;
        tick(4);
    endtask

    initial begin
        rst = 1'b0;
        main_det = 0; left_det = 0; sec_det = 0; p_btn = 0; emg_req = 0;
        m_LRYG = 4'b0100;
        s_RYG  = 3'b100;
        p      = 1'b0;

        // Reset held with inputs toggling
        for (int k = 0; k < 8; k++) begin
            main_det = ~main_det; left_det = ~left_det; sec_det = ~sec_det;
            p_btn = ~p_btn; emg_req = ~emg_req;
            tick();
        end
        check_eq("rst_counts", {main_num, left_num, sec_num, p_num}, 12'd0);
        check_eq("rst_emg", s_emergency, 1'b0);
`ifdef QUEUE_OVF_EN
        check_eq("rst_ovf", ovf, 4'd0);
`endif
        main_det = 0; left_det = 0; sec_det = 0; p_btn = 0; emg_req = 0;
        tick();
        rst = 1'b1;
        tick(3);

        // Arrival latency: raw high at edge 1 counts at edge 6
        main_det = 1'b1;
        tick(5);
        check_eq("main_edge5", main_num, 3'd0);
        tick();
        check_eq("main_edge6", main_num, 3'd1);
        tick(4);
        main_det = 1'b0;
        tick(4);
        check_eq("main_one_arrival", main_num, 3'd1);

        // Glitch rejection on left lane
        left_det = 1'b1; tick(2);
        left_det = 1'b0; tick(1);
        left_det = 1'b1; tick(2);
        left_det = 1'b0; tick(4);
        check_eq("left_glitch", left_num, 3'd0);
        pulse(2, 5);
        check_eq("left_clean", left_num, 3'd1);

        // Saturation on secondary lane
        for (int k = 0; k < 7; k++) pulse(1, 5);
        check_eq("sec_at7", sec_num, 3'd7);
`ifdef QUEUE_OVF_EN
        check_eq("ovf_before_sat", ovf, 4'b0000);
`endif
        pulse(1, 5);
        pulse(1, 5);
        check_eq("sec_hold7", sec_num, 3'd7);
`ifdef QUEUE_OVF_EN
        check_eq("ovf_sec_set", ovf, 4'b0010);
`endif
        s_RYG = 3'b001;
        tick(28);
        check_eq("sec_drained", sec_num, 3'd0);
        s_RYG = 3'b100;
        tick();
`ifdef QUEUE_OVF_EN
        check_eq("ovf_sticky", ovf, 4'b0010);
`endif
        check_eq("main_untouched", main_num, 3'd1);

        // Discharge of main lane: 3 -> 2,1,0 at green cycles 4, 8, 12
        pulse(3, 5);
        pulse(3, 5);
        check_eq("main_at3", main_num, 3'd3);
        exp_q = '{3'd3, 3'd3, 3'd3, 3'd2, 3'd2, 3'd2, 3'd2,
                  3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0};
        m_LRYG = 4'b0001;
        while (exp_q.size() > 0) begin
            tick();
            check_eq("main_discharge", main_num, exp_q.pop_front());
        end
        m_LRYG = 4'b0100;

        // Partial green period is lost
        pulse(3, 5);
        m_LRYG = 4'b0001; tick(2);
        m_LRYG = 4'b0100; tick(1);
        m_LRYG = 4'b0001; tick(3);
        check_eq("main_partial", main_num, 3'd1);
        tick(1);
        check_eq("main_full_period", main_num, 3'd0);

        // Left arrow and main green together: independent discharge
        m_LRYG = 4'b1001;
        tick(3);
        check_eq("left_before_dep", left_num, 3'd1);
        tick(1);
        check_eq("left_dep", left_num, 3'd0);
        check_eq("main_floor", main_num, 3'd0);
        m_LRYG = 4'b0100;

        // Pedestrian count
        for (int k = 0; k < 4; k++) pulse(0, 5);
        check_eq("ped_4", p_num, 3'd4);
        p = 1'b1;
        tick();
        check_eq("ped_walk_clear", p_num, 3'd0);
        pulse(0, 5);
        check_eq("ped_walk_discard", p_num, 3'd0);
        p = 1'b0;
        pulse(0, 5);
        check_eq("ped_after_walk", p_num, 3'd1);

        // Emergency: high 5 samples, low from edge 6; off at edge 24
        check_eq("emg_idle", s_emergency, 1'b0);
        emg_req = 1'b1;
        tick(2);
        check_eq("emg_edge2", s_emergency, 1'b0);
        tick();
        check_eq("emg_edge3", s_emergency, 1'b1);
        tick(2);
        emg_req = 1'b0;
        for (int e = 6; e <= 23; e++) begin
            tick();
            check_eq("emg_hold_high", s_emergency, 1'b1);
        end
        tick();
        check_eq("emg_edge24_off", s_emergency, 1'b0);
        tick(3);

        // Reassert during hold keeps s_emergency continuously high
        emg_req = 1'b1;
        tick(3);
        check_eq("emg_re_on", s_emergency, 1'b1);
        emg_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_eq("emg_reassert_hold", s_emergency, 1'b1);
        end
        emg_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check_eq("emg_reassert_active", s_emergency, 1'b1);
        end
        emg_req = 1'b0;
        tick(30);
        check_eq("emg_final_off", s_emergency, 1'b0);

        // Asynchronous reset mid-hold, with a nonzero count
        emg_req = 1'b1;
        tick(3);
        emg_req = 1'b0;
        tick(4);
        check_eq("emg_pre_rst", s_emergency, 1'b1);
        rst = 1'b0;
        #2;
        check_eq("async_rst_emg", s_emergency, 1'b0);
        check_eq("async_rst_ped", p_num, 3'd0);
        tick(2);
        rst = 1'b1;
        tick(2);
        check_eq("post_rst_emg", s_emergency, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
